config_chain_loader: RTL
========================

# config_chain_loader

Bitstream loader that sits directly upstream of a tile's configuration shift chain. It accepts fixed-width configuration words from a host over a valid/ready handshake and serialises them, LSB first, onto `shift_out`, which feeds the first tile's `shift_in_hard`. It gates `cen_out` per bit, so the chain advances only on valid bits. After exactly CHAIN_LEN bits it pulses `set_out`, which feeds `set_in_hard`, so all tiles latch their configuration together.

## Interface
- WORD_W, 32, host word width in bits (≥2)
- CHAIN_LEN, 2048, total bits in the downstream chain (≥1; need not be a multiple of WORD_W)
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived; do not override)

- clk  in  1  fabric clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE
- word_in  in  WORD_W  configuration word
- word_valid  in  1  word_in valid
- word_ready  out  1  loader accepts word this cycle
- busy  out  1  high from the cycle after start through the cycle after the set pulse
- done  out  1  one-cycle pulse when a load completes
- shift_out  out  1  serial bit to the chain
- cen_out  out  1  chain shift enable; high only when shift_out carries a valid bit
- set_out  out  1  one-cycle configuration latch pulse

## Operation
- States: IDLE, LOAD, SET, DONE.
- IDLE:
  - word_ready=0, cen_out=0.
  - start=1 → LOAD; remaining-bit counter rem=CHAIN_LEN; word bit counter wcnt=0.
- LOAD, accept: word_ready=1 when (wcnt==0 or wcnt==1) and rem > wcnt.
  - On word_valid&&word_ready, load the shift register with word_in and set wcnt=min(WORD_W, rem−wcnt_pending).
- LOAD, shift: each cycle with wcnt>0:
  - shift_out=sreg[0], cen_out=1.
  - sreg>>=1, wcnt−=1, rem−=1.
- LOAD, bubbles: wcnt==0 with no accepted word gives cen_out=0 and shift_out=0; the chain holds.
- LOAD, final word: only the low rem bits are shifted. The upper bits are discarded with no cen_out.
- LOAD exit: rem reaching 0 → SET.
- SET: set_out=1 for one cycle, cen_out=0 → DONE.
- DONE: done=1 for one cycle → IDLE.
- start while busy is ignored.
- Words offered after the final word is accepted are not taken: word_ready=0.

## Timing
- Reset values: word_ready=0, busy=0, done=0, shift_out=0, cen_out=0, set_out=0, state=IDLE.
- Reset mid-load aborts immediately and asynchronously. set_out is never asserted, and chain contents are undefined.
- Start to ready: start in cycle t → word_ready=1 in t+1.
- Word to first bit: word accepted at t → bit 0 on shift_out with cen_out=1 at t+1, bit k at t+1+k.
- Back-to-back words: word_ready re-asserts during the last bit cycle of the current word. With word_valid held high, the next word's bit 0 follows with no bubble, so cen_out is continuous.
- Minimum load length: with no bubbles, a full load takes 1 + CHAIN_LEN + 2 cycles from start to done.
- Set timing: set_out asserts the cycle after the last cen_out=1 cycle, and done follows one cycle later.
- Outputs: registered, no combinational path from inputs to outputs except none. word_ready depends only on state.

## Structure
- Package config_loader_pkg:
  - state enum: IDLE, LOAD, SET, DONE
  - CNT_W helper function
- Sub-module cfg_piso: WORD_W parallel-in/serial-out register.
  - Inputs: load, data, count.
  - Outputs: bit, bit_valid, last.
  - The FSM and rem counter live in config_chain_loader.

## Test plan
- WORD_W=32, CHAIN_LEN=64, words 0xA5A5_0001 and 0x8000_FFFF streamed back-to-back:
  - cen_out high for exactly 64 consecutive cycles.
  - shift_out sequence is 1,0,0,0,… (LSB first).
  - set_out pulses at cycle 66 after start; done at 67.
- CHAIN_LEN=40, two words 0xFFFF_FFFF and 0xFFFF_FFFF:
  - exactly 40 cen_out cycles;
  - word_ready low after the second accept; a third offered word is never taken.
- word_valid de-asserted for 5 cycles between words: cen_out low during the gap, total cen_out count still CHAIN_LEN, set_out once.
- rst asserted after 20 shifted bits: all outputs 0 asynchronously; set_out never seen. A new start reloads from rem=CHAIN_LEN.
- start pulsed again mid-LOAD and during SET: ignored, no extra set_out or done.
- CHAIN_LEN=1, word 0x0000_0003: a single cen_out cycle with shift_out=1, set_out on the next cycle.

Source files
------------

// File: rtl/config_loader_pkg.sv
// Shared state encoding and counter sizing for the configuration chain loader.
package config_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSet,
        StDone
    } state_e;

    // Width needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Host word handshake plus the serial chain drive of the configuration loader.
interface config_chain_loader_if #(
    parameter int unsigned WORD_W = 32
);

    logic              start;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              busy;
    logic              done;
    logic              shift_out;
    logic              cen_out;
    logic              set_out;

    modport master (
        output start, word_in, word_valid,
        input  word_ready, busy, done, shift_out, cen_out, set_out
    );

    modport slave (
        input  start, word_in, word_valid,
        output word_ready, busy, done, shift_out, cen_out, set_out
    );

endinterface

// File: rtl/cfg_piso.sv
// Parallel-in/serial-out word register; emits i_count bits LSB first after a load.
module cfg_piso
    import config_loader_pkg::*;
#(
    parameter int unsigned  WORD_W = 32,
    localparam int unsigned WCNT_W = cnt_width(WORD_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [WCNT_W-1:0] i_count,
    output logic              o_bit,
    output logic              o_bit_valid,
    output logic              o_last
);

    logic [WORD_W-1:0] r_sreg;
    logic [WCNT_W-1:0] r_wcnt;

    // A load during the final bit replaces the word at the same edge that retires that bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sreg <= '0;
            r_wcnt <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
            r_wcnt <= i_count;
        end else if (r_wcnt != '0) begin
            r_sreg <= r_sreg >> 1;
            r_wcnt <= r_wcnt - WCNT_W'(1);
        end
    end

    assign o_bit_valid = (r_wcnt != '0);
    assign o_last      = (r_wcnt == WCNT_W'(1));
    assign o_bit       = o_bit_valid & r_sreg[0];

endmodule

// File: rtl/config_chain_loader.sv
// Serialises host configuration words onto a tile shift chain, then pulses the chain latch.
module config_chain_loader
    import config_loader_pkg::*;
#(
    parameter int unsigned  WORD_W    = 32,
    parameter int unsigned  CHAIN_LEN = 2048,
    localparam int unsigned CNT_W     = cnt_width(CHAIN_LEN),
    localparam int unsigned WCNT_W    = cnt_width(WORD_W)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    config_chain_loader_if.slave io_bus
);

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_rem, w_rem_nxt, w_avail;
    logic [WCNT_W-1:0] w_count;
    logic              w_bit, w_bit_valid, w_last, w_ready, w_accept;

    // Take a word while the piso is empty or on its last bit, if bits beyond it are still owed.
    assign w_ready  = (r_state == StLoad) && (!w_bit_valid || w_last) &&
                      (r_rem > CNT_W'(w_bit_valid));
    assign w_accept = w_ready && io_bus.word_valid;
    assign w_avail  = r_rem - CNT_W'(w_bit_valid);
    assign w_count  = (32'(w_avail) >= WORD_W) ? WCNT_W'(WORD_W) : WCNT_W'(w_avail);

    cfg_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_accept),
        .i_data      (io_bus.word_in),
        .i_count     (w_count),
        .o_bit       (w_bit),
        .o_bit_valid (w_bit_valid),
        .o_last      (w_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_state_nxt = StLoad;
                    w_rem_nxt   = CNT_W'(CHAIN_LEN);
                end
            end
            StLoad: begin
                if (w_bit_valid) begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = StSet;
                    end
                end
            end
            StSet:   w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    assign io_bus.word_ready = w_ready;
    assign io_bus.busy       = (r_state != StIdle);
    assign io_bus.done       = (r_state == StDone);
    assign io_bus.set_out    = (r_state == StSet);
    assign io_bus.cen_out    = w_bit_valid;
    assign io_bus.shift_out  = w_bit;

endmodule
